switch_select_ctrl: RTL and testbench
=====================================

Name: switch_select_ctrl

Overview:
- Front-end controller between the 18 board slide switches and the LCD command path.
- Synchronizes and debounces the switch bank, then validates that exactly one switch is on.
- Converts the active switch to a 5-bit selection code and issues it once per press over a valid/ready handshake to the LCD writer.
- Blocks any new selection until all switches have been released and stable.

Parameters:
- N_SW, 18, number of switch inputs.
- CODE_W, 5, width of the selection code (must satisfy 2^CODE_W > N_SW).
- DEB_CYCLES, 50000, consecutive stable cycles required to accept a press or a release (minimum 2).
- REPEAT_CYCLES, 5000000, auto-repeat period; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sw  in  N_SW  raw asynchronous switch levels.
- cmd_ready  in  1  LCD writer accepts cmd_code this cycle.
- cmd_valid  out  1  selection code offered.
- cmd_code  out  CODE_W  selection code; switch bit i maps to code i+1; 0 means none.
- err_multi  out  1  debounced pattern had more than one switch on.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: clocking on rst returns the block to IDLE. cmd_valid=0, cmd_code=0, err_multi=0, busy=0, synchronizer flops=0, counters=0.
- Reset mid-handshake: drops cmd_valid with no transfer.
- Synchronizer: two flip-flops per bit; sw_s is the second stage. The FSM uses only sw_s.
- Code rule: one-hot sw_s bit i gives code i+1 (1..18). A zero or multi-bit pattern gives code 0 with onehot=0.
- FSM states are IDLE, SETTLE, ISSUE, HOLD.
- IDLE:
  - If sw_s != 0: capture snap<=sw_s, cnt<=0, go to SETTLE.
- SETTLE:
  - If sw_s == 0: go to IDLE.
  - Else if sw_s != snap: snap<=sw_s, cnt<=0.
  - Else if cnt == DEB_CYCLES-1 and onehot: latch cmd_code, go to ISSUE.
  - Else if cnt == DEB_CYCLES-1 and not onehot: err_multi<=1, go to HOLD.
  - Else cnt<=cnt+1.
- ISSUE:
  - cmd_valid=1; cmd_code stays constant until the transfer.
  - Transfer occurs on a cycle with cmd_valid && cmd_ready; the next state is HOLD and cmd_valid falls on the following cycle.
  - Switch changes during ISSUE are ignored. A request is never withdrawn except by rst.
- HOLD:
  - cnt counts consecutive cycles with sw_s == 0. Any nonzero sw_s resets cnt to 0.
  - When cnt reaches DEB_CYCLES-1: go to IDLE, clear err_multi, set cmd_code<=0.
- Latency: with sw constant from cycle 0, cmd_valid is high from cycle DEB_CYCLES+3.
- Throughput: at most one command per press/release cycle.
- Counter width is clog2(max(DEB_CYCLES, REPEAT_CYCLES)). The counter saturates and never wraps.
- Simultaneous events: in SETTLE, a change of sw_s on the terminal count cycle restarts the count (change wins).

Optional Feature:
- Macro: SWSEL_REPEAT_EN.
- With the macro defined, auto-repeat applies in HOLD.
  - Condition: err_multi=0 and sw_s still equals the issued one-hot pattern.
  - After REPEAT_CYCLES such consecutive cycles, go back to ISSUE with the same code and restart the repeat count after the transfer.
  - Any difference from the issued pattern falls back to the normal release count.
- Without the macro there is no auto-repeat, REPEAT_CYCLES is ignored and no repeat logic is synthesized.

Decomposition:
- Package swsel_pkg holds:
  - state enum (IDLE, SETTLE, ISSUE, HOLD);
  - CODE_NONE=0;
  - default N_SW and CODE_W;
  - a clog2-based counter width helper.
- Sub-module sw_onehot_enc is purely combinational: input sw_s; outputs code (CODE_W) and onehot. It is instantiated once, and its rule is the code rule above.

Test Plan (DEB_CYCLES=4, REPEAT_CYCLES=10):
- Press and accept: sw=0x00008 held, cmd_ready=1 -> cmd_valid one cycle at cycle 7 with cmd_code=4; no further command until release.
- Backpressure: sw=0x20000, cmd_ready=0 for 5 cycles then 1 -> cmd_valid held 6 cycles with cmd_code=18 constant; one transfer.
- Multi-switch error: sw=0x00005 stable -> err_multi=1, no cmd_valid; release for 4+ cycles -> err_multi=0, busy=0.
- Bounce: sw toggles 0x00001/0x00000 every 2 cycles for 20 cycles, then 0x00001 stable -> exactly one command, code=1, after the stable window.
- Release gating: after the transfer, sw goes 0 for 2 cycles then back to 0x00001 -> no new command; a full 4-cycle zero window followed by a press -> second command.
- Reset mid-ISSUE: rst during cmd_valid=1 with cmd_ready=0 -> next cycle all outputs 0, state IDLE.
- With SWSEL_REPEAT_EN, holding sw=0x00002 -> code=2 reissued every 10 HOLD cycles.

Source files
------------

// File: rtl/swsel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : swsel_pkg
//  Description : Shared types and constants for the switch selection front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package swsel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ISSUE  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam int c_N_SW      = 18;
    localparam int c_CODE_W    = 5;
    localparam int c_CODE_NONE = 0;

    // Width able to hold max(a, b) - 1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_onehot_enc.sv
`default_nettype none
// ============================================================================
//  Module      : sw_onehot_enc
//  Description : One-hot switch pattern to selection code (bit i -> i+1).
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_onehot_enc
    import swsel_pkg::*;
#(
    parameter int N_SW   = c_N_SW,
    parameter int CODE_W = c_CODE_W
) (
    input  logic [N_SW-1:0]   sw_s,
    output logic [CODE_W-1:0] code,
    output logic              onehot
);

    localparam logic [N_SW-1:0] c_ONE = N_SW'(1);

    always_comb begin
        onehot = (sw_s != '0) && ((sw_s & (sw_s - c_ONE)) == '0);
        code   = CODE_W'(c_CODE_NONE);
        for (int i = 0; i < N_SW; i++) begin
            if (onehot && sw_s[i]) code = CODE_W'(i + 1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/switch_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : switch_select_ctrl
//  Description : Debounced single-switch selection issued over valid/ready.
//                Optional auto-repeat in HOLD when SWSEL_REPEAT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_select_ctrl
    import swsel_pkg::*;
#(
    parameter int N_SW          = c_N_SW,
    parameter int CODE_W        = c_CODE_W,
    parameter int DEB_CYCLES    = 50000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SW-1:0]   sw,
    input  logic              cmd_ready,
    output logic              cmd_valid,
    output logic [CODE_W-1:0] cmd_code,
    output logic              err_multi,
    output logic              busy
);

    localparam int                 c_CNT_W    = cnt_width(DEB_CYCLES, REPEAT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEB_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CODE_W-1:0]  c_CODE_0   = CODE_W'(c_CODE_NONE);

    logic [N_SW-1:0]    r_sw_m, r_sw_s, r_snap, w_snap_nxt;
    state_t             r_state, w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [CODE_W-1:0]  r_code, w_code_nxt, w_enc_code;
    logic               r_err, w_err_nxt, w_enc_onehot;

`ifdef SWSEL_REPEAT_EN
    localparam logic [c_CNT_W-1:0] c_RPT_LAST = c_CNT_W'(REPEAT_CYCLES - 1);
    logic [c_CNT_W-1:0] r_rpt, w_rpt_nxt, w_rpt_inc;
    assign w_rpt_inc = (r_rpt == c_CNT_MAX) ? r_rpt : r_rpt + c_CNT_W'(1);
`endif

    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + c_CNT_W'(1);

    sw_onehot_enc #(
        .N_SW   (N_SW),
        .CODE_W (CODE_W)
    ) u_enc (
        .sw_s   (r_sw_s),
        .code   (w_enc_code),
        .onehot (w_enc_onehot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_m  <= '0;
            r_sw_s  <= '0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_snap  <= '0;
            r_code  <= c_CODE_0;
            r_err   <= 1'b0;
`ifdef SWSEL_REPEAT_EN
            r_rpt   <= '0;
`endif
        end else begin
            r_sw_m  <= sw;
            r_sw_s  <= r_sw_m;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_snap  <= w_snap_nxt;
            r_code  <= w_code_nxt;
            r_err   <= w_err_nxt;
`ifdef SWSEL_REPEAT_EN
            r_rpt   <= w_rpt_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_snap_nxt  = r_snap;
        w_code_nxt  = r_code;
        w_err_nxt   = r_err;
`ifdef SWSEL_REPEAT_EN
        w_rpt_nxt   = r_rpt;
`endif
        case (r_state)
            IDLE: begin
                if (r_sw_s != '0) begin
                    w_snap_nxt  = r_sw_s;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                // A pattern change outranks the terminal count.
                if (r_sw_s == '0) begin
                    w_state_nxt = IDLE;
                end else if (r_sw_s != r_snap) begin
                    w_snap_nxt = r_sw_s;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_enc_onehot) begin
                        w_code_nxt  = w_enc_code;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = HOLD;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = HOLD;
`ifdef SWSEL_REPEAT_EN
                    w_rpt_nxt   = '0;
`endif
                end
            end
            HOLD: begin
                if (r_sw_s != '0) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_DEB_LAST) begin
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                    w_code_nxt  = c_CODE_0;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
`ifdef SWSEL_REPEAT_EN
                // Still holding the issued switch: reissue the same code.
                if (!r_err && (r_sw_s == r_snap)) begin
                    if (r_rpt == c_RPT_LAST) begin
                        w_rpt_nxt   = '0;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_rpt_nxt = w_rpt_inc;
                    end
                end else begin
                    w_rpt_nxt = '0;
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign cmd_valid = (r_state == ISSUE);
    assign cmd_code  = r_code;
    assign err_multi = r_err;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_switch_select_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_select_ctrl
//  Description : Directed self-checking bench, DEB_CYCLES=4, REPEAT_CYCLES=10.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_select_ctrl;

    localparam int c_N_SW   = 18;
    localparam int c_CODE_W = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic [c_N_SW-1:0]   sw;
    logic                cmd_ready;
    logic                cmd_valid;
    logic [c_CODE_W-1:0] cmd_code;
    logic                err_multi;
    logic                busy;

    int                  n_checks  = 0;
    int                  n_pass    = 0;
    int                  n_xfer    = 0;
    logic [c_CODE_W-1:0] last_code = '0;

    always #5 clk = ~clk;

    switch_select_ctrl #(
        .N_SW          (c_N_SW),
        .CODE_W        (c_CODE_W),
        .DEB_CYCLES    (4),
        .REPEAT_CYCLES (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .err_multi (err_multi),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One cycle; a handshake visible now completes on the coming edge.
    task automatic tick();
        if (!rst && cmd_valid && cmd_ready) begin
            n_xfer++;
            last_code = cmd_code;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1; sw = '0; cmd_ready = 1'b1;
        ticks(3);
        check("rst_valid", cmd_valid, 0);
        check("rst_code",  cmd_code,  0);
        check("rst_err",   err_multi, 0);
        check("rst_busy",  busy,      0);
        rst = 1'b0;

        // Press and accept: valid first seen 7 cycles after the press.
        sw = 18'h00008;
        ticks(6);
        check("p1_valid_t6", cmd_valid, 0);
        check("p1_busy_t6",  busy,      1);
        tick();
        check("p1_valid_t7", cmd_valid, 1);
        check("p1_code_t7",  cmd_code,  4);
        tick();
        check("p1_valid_t8", cmd_valid, 0);
        check("p1_xfer",     n_xfer,    1);
        check("p1_lastcode", last_code, 4);
        ticks(20);
        check("p1_no_repeat", n_xfer, 1);
        check("p1_hold_busy", busy,   1);
        sw = '0;
        ticks(5);
        check("rel_busy_t5", busy, 1);
        tick();
        check("rel_busy_t6", busy,     0);
        check("rel_code_t6", cmd_code, 0);

        // Backpressure: five stalled cycles, accepted on the sixth.
        sw = 18'h20000; cmd_ready = 1'b0;
        ticks(7);
        for (int j = 0; j < 6; j++) begin
            check("bp_valid", cmd_valid, 1);
            check("bp_code",  cmd_code,  18);
            if (j == 5) cmd_ready = 1'b1;
            tick();
        end
        check("bp_valid_after", cmd_valid, 0);
        check("bp_xfer",        n_xfer,    2);
        check("bp_lastcode",    last_code, 18);
        sw = '0;
        ticks(6);
        check("bp_idle", busy, 0);

        // Two switches on: error flag, no command.
        sw = 18'h00005;
        ticks(7);
        check("mu_err",   err_multi, 1);
        check("mu_valid", cmd_valid, 0);
        check("mu_busy",  busy,      1);
        ticks(5);
        check("mu_xfer",      n_xfer,    2);
        check("mu_err_held",  err_multi, 1);
        sw = '0;
        ticks(5);
        check("mu_err_t5", err_multi, 1);
        tick();
        check("mu_err_clr",  err_multi, 0);
        check("mu_busy_clr", busy,      0);

        // Bounce never completes a debounce window.
        for (int k = 0; k < 5; k++) begin
            sw = 18'h00001; ticks(2);
            sw = '0;        ticks(2);
        end
        check("bn_xfer_during", n_xfer, 2);
        sw = 18'h00001;
        ticks(6);
        check("bn_valid_t6", cmd_valid, 0);
        tick();
        check("bn_valid_t7", cmd_valid, 1);
        check("bn_code_t7",  cmd_code,  1);
        tick();
        check("bn_xfer",     n_xfer,    3);
        check("bn_lastcode", last_code, 1);

        // Short release does not re-arm; a full window does.
        sw = '0;         ticks(2);
        sw = 18'h00001;  ticks(10);
        check("rg_xfer",  n_xfer,    3);
        check("rg_busy",  busy,      1);
        check("rg_valid", cmd_valid, 0);
        sw = '0;
        ticks(6);
        check("rg_idle", busy, 0);
        sw = 18'h00001;
        ticks(7);
        check("rg_valid2", cmd_valid, 1);
        check("rg_code2",  cmd_code,  1);
        tick();
        check("rg_xfer2", n_xfer, 4);

        // Pattern change on the terminal count cycle restarts the window.
        sw = '0;
        ticks(6);
        check("tc_idle", busy, 0);
        sw = 18'h00001;
        ticks(4);
        sw = 18'h00002;
        ticks(3);
        check("tc_valid_t7", cmd_valid, 0);
        check("tc_busy_t7",  busy,      1);
        ticks(4);
        check("tc_valid_t11", cmd_valid, 1);
        check("tc_code_t11",  cmd_code,  2);
        tick();
        check("tc_xfer",     n_xfer,    5);
        check("tc_lastcode", last_code, 2);

        // Reset while a request is stalled.
        sw = '0;
        ticks(6);
        check("rs_idle", busy, 0);
        sw = 18'h00100; cmd_ready = 1'b0;
        ticks(7);
        check("rs_valid_pre", cmd_valid, 1);
        check("rs_code_pre",  cmd_code,  9);
        rst = 1'b1;
        tick();
        check("rs_valid", cmd_valid, 0);
        check("rs_code",  cmd_code,  0);
        check("rs_err",   err_multi, 0);
        check("rs_busy",  busy,      0);
        rst = 1'b0; sw = '0; cmd_ready = 1'b1;
        ticks(3);
        check("rs_xfer",       n_xfer, 5);
        check("rs_busy_after", busy,   0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
